// File: rtl/aes_fifo_pkg.sv
// Shared constants for the AES256 block/word FIFOs.
// Used by both the gathering and serializing FIFOs.
package aes_fifo_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 8;
  localparam int BLK_W         = 256;
  localparam int WIDX_W        = 3;

  typedef logic [WIDX_W-1:0] widx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mod_fifo_8to1_if.sv
// Block-write / word-read bus of the 8:1 serializer FIFO.
// FIFO_8TO1_OVF_EN adds the sticky ovf_err signal.
interface mod_fifo_8to1_if #(
  parameter int DEPTH_BLK = 4
);
  import aes_fifo_pkg::*;

  localparam int LVL_W = $clog2(DEPTH_BLK + 1);

  logic [BLK_W-1:0]  inp_blk;
  logic              wr_blk;
  logic              blk_ready;
  logic [WORD_W-1:0] outp_word;
  logic              word_valid;
  logic              rd_word;
  logic              last_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level;
`ifdef FIFO_8TO1_OVF_EN
  logic              ovf_err;

  modport master (
    output inp_blk, wr_blk, rd_word,
    input  blk_ready, outp_word, word_valid,
    input  last_word, fifo_full, fifo_empty,
    input  level, ovf_err
  );

  modport slave (
    input  inp_blk, wr_blk, rd_word,
    output blk_ready, outp_word, word_valid,
    output last_word, fifo_full, fifo_empty,
    output level, ovf_err
  );
`else
  modport master (
    output inp_blk, wr_blk, rd_word,
    input  blk_ready, outp_word, word_valid,
    input  last_word, fifo_full, fifo_empty,
    input  level
  );

  modport slave (
    input  inp_blk, wr_blk, rd_word,
    output blk_ready, outp_word, word_valid,
    output last_word, fifo_full, fifo_empty,
    output level
  );
`endif

endinterface

// File: rtl/mod_word_mux.sv
// 256-to-32 word selector; word k is blk_i[32k+31:32k].
// Purely combinational.
module mod_word_mux
  import aes_fifo_pkg::*;
(
  input  logic [BLK_W-1:0]  blk_i,
  input  widx_t             idx_i,
  output logic [WORD_W-1:0] word_o
);

  assign word_o = blk_i[int'(idx_i)*WORD_W +: WORD_W];

endmodule

// File: rtl/mod_fifo_8to1.sv
// 256-bit block to 32-bit word serializer FIFO.
// Define FIFO_8TO1_OVF_EN for the sticky ovf_err output.
module mod_fifo_8to1
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH_BLK = 4
) (
  input logic             clk,
  input logic             reset,
  mod_fifo_8to1_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH_BLK);
  localparam int LVL_W = $clog2(DEPTH_BLK + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LVL_W-1:0] lvl_t;

  logic [BLK_W-1:0] mem_q [DEPTH_BLK];

  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  lvl_t      level_q, level_d;
  widx_t     widx_q, widx_d;
  rd_state_e state;

  logic blk_ready;
  logic wr_acc;
  logic rd_acc;
  logic retire;

  assign blk_ready = (level_q < lvl_t'(DEPTH_BLK));
  assign wr_acc    = bus.wr_blk & blk_ready;
  assign rd_acc    = bus.rd_word & bus.word_valid;
  assign retire    = rd_acc & (widx_q == widx_t'(7));

  assign bus.blk_ready  = blk_ready;
  assign bus.fifo_full  = (level_q == lvl_t'(DEPTH_BLK));
  assign bus.fifo_empty = (level_q == '0);
  assign bus.level      = level_q;

  // Read-side state follows the registered block count.
  always_comb begin
    state = (level_q == '0) ? RD_IDLE : RD_SEND;
  end

  // Pointer, word index and level next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    widx_d   = widx_q;
    level_d  = level_q;
    if (wr_acc)
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) begin
      if (widx_q == widx_t'(7)) begin
        widx_d   = '0;
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end else begin
        widx_d = widx_q + widx_t'(1);
      end
    end
    unique case ({wr_acc, retire})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase
  end

  // Read-side outputs decoded from state and word index.
  always_comb begin
    bus.word_valid = 1'b0;
    bus.last_word  = 1'b0;
    unique case (state)
      RD_SEND: begin
        bus.word_valid = 1'b1;
        bus.last_word  = (widx_q == widx_t'(7));
      end
      default: begin
        bus.word_valid = 1'b0;
        bus.last_word  = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      widx_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      widx_q   <= widx_d;
    end
  end

  // Block storage; cleared so outp_word reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BLK; i++)
        mem_q[i] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.inp_blk;
    end
  end

  mod_word_mux u_mux (
    .blk_i  (mem_q[rd_ptr_q]),
    .idx_i  (widx_q),
    .word_o (bus.outp_word)
  );

`ifdef FIFO_8TO1_OVF_EN
  logic ovf_q;

  // Sticky flag for any write attempted without space.
  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (bus.wr_blk & ~blk_ready)
      ovf_q <= 1'b1;
  end

  assign bus.ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_mod_fifo_8to1.sv
// Scoreboard bench for mod_fifo_8to1.
// Build with FIFO_8TO1_OVF_EN to also cover ovf_err.
module tb_mod_fifo_8to1;
  import aes_fifo_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] w;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  mod_fifo_8to1_if #(.DEPTH_BLK(DEPTH)) bus ();

  mod_fifo_8to1 #(.DEPTH_BLK(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mk_blk(input logic [7:0] tag);
    logic [255:0] b;
    for (int k = 0; k < 8; k++)
      b[32*k +: 32] = {tag, 16'h0000, 8'(k)};
    return b;
  endfunction

  task automatic push_blk(input logic [7:0] tag);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.w = {tag, 16'h0000, 8'(k)};
      e.l = (k == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted read must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.word_valid && bus.rd_word) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word act=%h exp=none", bus.outp_word);
      end else begin
        e = exp_q.pop_front();
        chk("word", bus.outp_word, e.w);
        chk("last_word", 32'(bus.last_word), 32'(e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inp_blk = '0;
    bus.wr_blk  = 1'b0;
    bus.rd_word = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_last", 32'(bus.last_word), 32'd0);
    chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_ready", 32'(bus.blk_ready), 32'd1);
    chk("rst_word", bus.outp_word, 32'd0);
`ifdef FIFO_8TO1_OVF_EN
    chk("rst_ovf", 32'(bus.ovf_err), 32'd0);
`endif

    // single block, read held high through the write
    bus.inp_blk = mk_blk(8'h00);
    bus.wr_blk  = 1'b1;
    bus.rd_word = 1'b1;
    push_blk(8'h00);
    tick();
    bus.wr_blk = 1'b0;
    chk("lat_valid", 32'(bus.word_valid), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    bus.rd_word = 1'b0;
    chk("t1_empty", 32'(bus.fifo_empty), 32'd1);
    chk("t1_valid", 32'(bus.word_valid), 32'd0);

    // fill to full, then a dropped write
    for (int b = 1; b <= 4; b++) begin
      bus.inp_blk = mk_blk(8'(8'hA0 + b));
      bus.wr_blk  = 1'b1;
      push_blk(8'(8'hA0 + b));
      tick();
    end
    chk("full_level", 32'(bus.level), 32'd4);
    chk("full_flag", 32'(bus.fifo_full), 32'd1);
    chk("full_ready", 32'(bus.blk_ready), 32'd0);
    bus.inp_blk = mk_blk(8'hEE);
    tick();
    bus.wr_blk = 1'b0;
    chk("drop_level", 32'(bus.level), 32'd4);
`ifdef FIFO_8TO1_OVF_EN
    chk("ovf_set", 32'(bus.ovf_err), 32'd1);
`endif

    // drain 32 words with no gaps
    bus.rd_word = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_valid", 32'(bus.word_valid), 32'd1);
      tick();
      if (i == 6) chk("drain_ready_lo", 32'(bus.blk_ready), 32'd0);
      if (i % 8 == 7)
        chk("drain_ready_hi", 32'(bus.blk_ready), 32'd1);
      if (i == 7) chk("drain_level", 32'(bus.level), 32'd3);
    end
    bus.rd_word = 1'b0;
    chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
`ifdef FIFO_8TO1_OVF_EN
    chk("ovf_sticky", 32'(bus.ovf_err), 32'd1);
`endif

    // write and retire in the same cycle at level 1
    bus.inp_blk = mk_blk(8'hC0);
    bus.wr_blk  = 1'b1;
    push_blk(8'hC0);
    tick();
    bus.wr_blk  = 1'b0;
    bus.rd_word = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("c_last", 32'(bus.last_word), 32'd1);
    bus.inp_blk = mk_blk(8'hD0);
    bus.wr_blk  = 1'b1;
    push_blk(8'hD0);
    tick();
    bus.wr_blk = 1'b0;
    chk("both_level", 32'(bus.level), 32'd1);
    chk("both_valid", 32'(bus.word_valid), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    bus.rd_word = 1'b0;
    chk("both_empty", 32'(bus.fifo_empty), 32'd1);

    // reset in the middle of a block
    bus.inp_blk = mk_blk(8'hE1);
    bus.wr_blk  = 1'b1;
    push_blk(8'hE1);
    tick();
    bus.inp_blk = mk_blk(8'hE2);
    push_blk(8'hE2);
    tick();
    bus.wr_blk  = 1'b0;
    bus.rd_word = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.rd_word = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk("mrst_level", 32'(bus.level), 32'd0);
    chk("mrst_valid", 32'(bus.word_valid), 32'd0);
    chk("mrst_word", bus.outp_word, 32'd0);
`ifdef FIFO_8TO1_OVF_EN
    chk("mrst_ovf", 32'(bus.ovf_err), 32'd0);
`endif
    bus.inp_blk = mk_blk(8'h5A);
    bus.wr_blk  = 1'b1;
    bus.rd_word = 1'b1;
    push_blk(8'h5A);
    tick();
    bus.wr_blk = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bus.rd_word = 1'b0;
    chk("post_empty", 32'(bus.fifo_empty), 32'd1);
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
